// File: rtl/hazard_if.sv
// Pipeline-hazard bundle: stage addresses/controls in, stall/flush/forward/status out.
// master = pipeline side driving stage state, slave = hazard_ctrl.
interface hazard_if;
  logic [4:0]  ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw;
  logic        regWrte, regWrtm, regWrtw, ldE, pcSrce, mcStarte;
  logic        stallf, stalld, stalle, flushd, flushe, flushm;
  logic [1:0]  fwdAe, fwdBe;
  logic        mcBusy;
  logic [15:0] stallCnt;

  modport master (
    output ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw,
           regWrte, regWrtm, regWrtw, ldE, pcSrce, mcStarte,
    input  stallf, stalld, stalle, flushd, flushe, flushm,
           fwdAe, fwdBe, mcBusy, stallCnt
  );

  modport slave (
    input  ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw,
           regWrte, regWrtm, regWrtw, ldE, pcSrce, mcStarte,
    output stallf, stalld, stalle, flushd, flushe, flushm,
           fwdAe, fwdBe, mcBusy, stallCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: load-use / RAW stalls, branch flushes, operand
// forwarding and a multi-cycle execute FSM. Macro HAZARD_FWD_EN selects forwarding vs RAW stalling.
module hazard_ctrl #(
  parameter int MC_LAT = 4
) (
  input  logic     clk,
  input  logic     clr_n,
  hazard_if.slave  hz
);

  typedef enum logic [1:0] {RUN, MC_BUSY, MC_DONE} state_t;

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

  state_t      state;
  logic [3:0]  mcCnt;
  logic        busy_q;
  logic [15:0] cnt_q;

  logic        busy, mc_take, lw_stall, raw_stall, br;
  logic        stall_c, flushd_c, flushe_c, flushm_c, stalle_c;
  logic [1:0]  fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       wm, input logic [4:0] dm,
    input logic       ww, input logic [4:0] dw
  );
    if (wm && dm != 5'd0 && dm == src)      return 2'b10;
    else if (ww && dw != 5'd0 && dw == src) return 2'b01;
    else                                    return 2'b00;
  endfunction

  always_comb begin
    busy     = (state == MC_BUSY);
    mc_take  = (state == RUN) && hz.mcStarte;
    lw_stall = !busy && hz.ldE && (hz.rde != 5'd0) &&
               ((hz.rde == hz.ad1d) || (hz.rde == hz.ad2d));
    // a starting multi-cycle op swallows a coincident redirect
    br       = !busy && hz.pcSrce && !mc_take;
  end

`ifdef HAZARD_FWD_EN
  logic unused_sink;
  assign unused_sink = hz.regWrte;
  assign raw_stall   = 1'b0;
  assign fwd_a       = fwd_sel(hz.ad1e, hz.regWrtm, hz.rdm, hz.regWrtw, hz.rdw);
  assign fwd_b       = fwd_sel(hz.ad2e, hz.regWrtm, hz.rdm, hz.regWrtw, hz.rdw);
`else
  logic unused_sink;
  logic raw1, raw2;
  assign unused_sink = ^{hz.ad1e, hz.ad2e, hz.rdw, hz.regWrtw};
  // W never stalls: the register file writes on the falling edge
  assign raw1 = (hz.ad1d != 5'd0) && ((hz.regWrte && hz.ad1d == hz.rde) ||
                                      (hz.regWrtm && hz.ad1d == hz.rdm));
  assign raw2 = (hz.ad2d != 5'd0) && ((hz.regWrte && hz.ad2d == hz.rde) ||
                                      (hz.regWrtm && hz.ad2d == hz.rdm));
  assign raw_stall = !busy && (raw1 || raw2);
  assign fwd_a     = 2'b00;
  assign fwd_b     = 2'b00;
`endif

  // reset forces every combinational control low, not just the state
  always_comb begin
    stall_c  = clr_n && (lw_stall || raw_stall || busy);
    stalle_c = clr_n && busy;
    flushd_c = clr_n && br;
    flushe_c = clr_n && (br || lw_stall || raw_stall);
    flushm_c = clr_n && busy;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= RUN;
      mcCnt  <= 4'd0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        RUN: if (hz.mcStarte) begin
          state  <= MC_BUSY;
          mcCnt  <= MC_LOAD;
          busy_q <= 1'b1;
        end
        MC_BUSY: if (mcCnt == 4'd0) begin
          state  <= MC_DONE;
          busy_q <= 1'b0;
        end else begin
          mcCnt  <= mcCnt - 4'd1;
        end
        default: begin
          state  <= RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                             cnt_q <= 16'd0;
    else if (stall_c && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end

  assign hz.stallf   = stall_c;
  assign hz.stalld   = stall_c;
  assign hz.stalle   = stalle_c;
  assign hz.flushd   = flushd_c;
  assign hz.flushe   = flushe_c;
  assign hz.flushm   = flushm_c;
  assign hz.fwdAe    = clr_n ? fwd_a : 2'b00;
  assign hz.fwdBe    = clr_n ? fwd_b : 2'b00;
  assign hz.mcBusy   = busy_q;
  assign hz.stallCnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MC_LAT=4); forwarding expectations follow HAZARD_FWD_EN.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic clr_n;
  int   n_vec = 0;
  int   n_err = 0;

  hazard_if hif();

  hazard_ctrl #(.MC_LAT(4)) dut (.clk(clk), .clr_n(clr_n), .hz(hif.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hif.ad1d = 0; hif.ad2d = 0; hif.ad1e = 0; hif.ad2e = 0;
    hif.rde = 0; hif.rdm = 0; hif.rdw = 0;
    hif.regWrte = 0; hif.regWrtm = 0; hif.regWrtw = 0;
    hif.ldE = 0; hif.pcSrce = 0; hif.mcStarte = 0;
  endtask

  task automatic clk1();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); clr_n = 0; #3; clr_n = 1; clk1();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fwd_on;
`ifdef HAZARD_FWD_EN
    fwd_on = 1;
`else
    fwd_on = 0;
`endif
    // reset with hazard-provoking inputs: everything must read zero
    idle(); clr_n = 0;
    hif.ldE = 1; hif.rde = 5; hif.ad1d = 5; hif.pcSrce = 1;
    hif.regWrtm = 1; hif.rdm = 7; hif.ad1e = 7;
    #1;
    chk("rst_stallf", 16'(hif.stallf), 16'd0);
    chk("rst_flushe", 16'(hif.flushe), 16'd0);
    chk("rst_flushd", 16'(hif.flushd), 16'd0);
    chk("rst_fwdA",   16'(hif.fwdAe),  16'd0);
    chk("rst_busy",   16'(hif.mcBusy), 16'd0);
    chk("rst_cnt",    hif.stallCnt,    16'd0);
    idle(); #10; clr_n = 1; clk1();

    // load-use on ad1d
    hif.ldE = 1; hif.rde = 5; hif.ad1d = 5; #1;
    chk("lw_stallf", 16'(hif.stallf), 16'd1);
    chk("lw_stalld", 16'(hif.stalld), 16'd1);
    chk("lw_flushe", 16'(hif.flushe), 16'd1);
    chk("lw_flushd", 16'(hif.flushd), 16'd0);
    clk1(); idle(); #1;
    chk("lw_cnt",    hif.stallCnt,    16'd1);
    chk("lw_clear",  16'(hif.stallf), 16'd0);
    // load-use on ad2d, and x0 load never stalls
    hif.ldE = 1; hif.rde = 6; hif.ad1d = 2; hif.ad2d = 6; #1;
    chk("lw_b", 16'(hif.stallf), 16'd1);
    hif.rde = 0; hif.ad1d = 0; hif.ad2d = 0; #1;
    chk("lw_x0", 16'(hif.stallf), 16'd0);
    idle();

    // forwarding
    hif.regWrtm = 1; hif.rdm = 7; hif.ad1e = 7;
    hif.regWrtw = 1; hif.rdw = 7; hif.ad2e = 7; #1;
    chk("fwdA_m", 16'(hif.fwdAe), fwd_on ? 16'd2 : 16'd0);
    chk("fwdB_w", 16'(hif.fwdBe), fwd_on ? 16'd1 : 16'd0);
    hif.ad2e = 7; hif.rdm = 7; hif.rdw = 7; hif.ad1e = 7; hif.ad2e = 3; #1;
    chk("fwdB_none", 16'(hif.fwdBe), 16'd0);
    hif.rdm = 0; hif.ad1e = 0; hif.rdw = 0; #1;
    chk("fwdA_x0", 16'(hif.fwdAe), 16'd0);
    idle();

    // RAW stall against E and M, never W, never x0
    hif.regWrte = 1; hif.rde = 9; hif.ad1d = 9; #1;
    chk("raw_e_stall", 16'(hif.stallf), fwd_on ? 16'd0 : 16'd1);
    chk("raw_e_flush", 16'(hif.flushe), fwd_on ? 16'd0 : 16'd1);
    idle(); hif.regWrtm = 1; hif.rdm = 9; hif.ad2d = 9; #1;
    chk("raw_m_stall", 16'(hif.stallf), fwd_on ? 16'd0 : 16'd1);
    idle(); hif.regWrtw = 1; hif.rdw = 9; hif.ad1d = 9; #1;
    chk("raw_w_none", 16'(hif.stallf), 16'd0);
    idle(); hif.regWrte = 1; hif.rde = 0; hif.ad1d = 0; #1;
    chk("raw_x0", 16'(hif.stallf), 16'd0);
    idle();

    // branch flush, alone and with a load-use
    hif.pcSrce = 1; #1;
    chk("br_flushd", 16'(hif.flushd), 16'd1);
    chk("br_flushe", 16'(hif.flushe), 16'd1);
    chk("br_stallf", 16'(hif.stallf), 16'd0);
    hif.ldE = 1; hif.rde = 3; hif.ad2d = 3; #1;
    chk("brlw_flushd", 16'(hif.flushd), 16'd1);
    chk("brlw_flushe", 16'(hif.flushe), 16'd1);
    chk("brlw_stallf", 16'(hif.stallf), 16'd1);
    idle();

    // multi-cycle op: start wins over a coincident branch
    do_reset();
    hif.mcStarte = 1; hif.pcSrce = 1; #1;
    chk("mc_start_flushd", 16'(hif.flushd), 16'd0);
    chk("mc_start_busy",   16'(hif.mcBusy), 16'd0);
    clk1(); idle();
    hif.pcSrce = 1; hif.ldE = 1; hif.rde = 3; hif.ad2d = 3; #1;
    chk("mc_br_flushd", 16'(hif.flushd), 16'd0);
    chk("mc_br_flushe", 16'(hif.flushe), 16'd0);
    chk("mc_flushm",    16'(hif.flushm), 16'd1);
    chk("mc_stalle",    16'(hif.stalle), 16'd1);
    idle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mc_busy%0d", i),  16'(hif.mcBusy), 16'd1);
      chk($sformatf("mc_stall%0d", i), 16'(hif.stallf), 16'd1);
      clk1();
    end
    chk("mc_done_busy",  16'(hif.mcBusy), 16'd0);
    chk("mc_done_stall", 16'(hif.stallf), 16'd0);
    chk("mc_done_flm",   16'(hif.flushm), 16'd0);
    chk("mc_cnt",        hif.stallCnt,    16'd3);
    clk1();
    chk("mc_run_busy",   16'(hif.mcBusy), 16'd0);
    hif.mcStarte = 1; clk1(); idle();
    chk("mc_restart",    16'(hif.mcBusy), 16'd1);

    // reset during the second busy cycle abandons the op
    clk1();
    chk("mc2_busy", 16'(hif.mcBusy), 16'd1);
    clr_n = 0; #1;
    chk("rstmc_busy",  16'(hif.mcBusy), 16'd0);
    chk("rstmc_stall", 16'(hif.stallf), 16'd0);
    chk("rstmc_cnt",   hif.stallCnt,    16'd0);
    #2; clr_n = 1; clk1();
    chk("rstmc_run_busy",  16'(hif.mcBusy), 16'd0);
    chk("rstmc_run_stall", 16'(hif.stallf), 16'd0);

    // saturation of the stall counter
    hif.ldE = 1; hif.rde = 5; hif.ad1d = 5;
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt_sat", hif.stallCnt, 16'hFFFF);
    clk1();
    chk("cnt_hold", hif.stallCnt, 16'hFFFF);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MC_LAT, default 4: execute-stage occupancy of a multi-cycle op in cycles; legal range 2..15.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 clr_n  in  1  asynchronous active-low reset.
REQ-004 ad1d, ad2d  in  5  decode-stage source register addresses.
REQ-005 ad1e, ad2e, rde  in  5  execute-stage source and destination addresses.
REQ-006 rdm, rdw  in  5  memory-stage and writeback-stage destination addresses.
REQ-007 regWrte, regWrtm, regWrtw  in  1  register-write enables for the E, M and W stages.
REQ-008 ldE  in  1  execute-stage instruction is a load (resltSrce==01).
REQ-009 pcSrce  in  1  taken branch or jump resolved in E.
REQ-010 mcStarte  in  1  execute-stage instruction is a multi-cycle op.
REQ-011 stallf, stalld, stalle  out  1  hold the PC, fetch/decode and decode/execute registers.
REQ-012 flushd, flushe, flushm  out  1  clear the fetch/decode, decode/execute and execute/memory registers.
REQ-013 fwdAe, fwdBe  out  2  ALU operand select: 00 register file, 01 W result, 10 M ALU result.
REQ-014 mcBusy  out  1  multi-cycle op in progress.
REQ-015 stallCnt  out  16  saturating count of cycles with stallf=1.

Function
REQ-016 FSM states: RUN, MC_BUSY, MC_DONE; a 4-bit down-counter mcCnt is part of the FSM.
REQ-017 RUN with mcStarte=1 goes to MC_BUSY and loads mcCnt=MC_LAT-2.
REQ-018 MC_BUSY with mcCnt==0 goes to MC_DONE; otherwise it stays in MC_BUSY and decrements mcCnt.
REQ-019 MC_DONE goes to RUN unconditionally after exactly one cycle.
REQ-020 In MC_BUSY: stallf=stalld=stalle=1, flushm=1, flushd=flushe=0, and pcSrce, ldE and RAW checks are ignored.
REQ-021 mcBusy=1 exactly in MC_BUSY, so the E stage is frozen for MC_LAT-1 cycles plus one MC_DONE cycle (MC_LAT total).
REQ-022 In RUN or MC_DONE, lwStall = ldE & (rde!=0) & ((rde==ad1d)|(rde==ad2d)).
REQ-023 stallf = stalld = lwStall | rawStall | (state==MC_BUSY).
REQ-024 flushd = pcSrce outside MC_BUSY.
REQ-025 flushe = (pcSrce | lwStall | rawStall) outside MC_BUSY.
REQ-026 When pcSrce=1 and lwStall=1 coincide, flushd=flushe=1 and stallf=stalld=1.
REQ-027 When mcStarte=1 and pcSrce=1 coincide in RUN, mcStarte wins: the transition is taken and pcSrce is ignored.
REQ-028 fwdAe=10 when regWrtm & rdm!=0 & rdm==ad1e; else 01 when regWrtw & rdw!=0 & rdw==ad1e; else 00; fwdBe is identical with ad2e.
REQ-029 All stall, flush and forward outputs are combinational from inputs and state; only FSM state, mcCnt and stallCnt are registered.
REQ-030 stallCnt increments on each clock edge where stallf=1 and saturates at 0xFFFF.
REQ-031 Register x0 never causes a hazard, a forward or a RAW stall.

Reset
REQ-032 clr_n=0 asynchronously forces state=RUN, mcCnt=0 and stallCnt=0.
REQ-033 During reset, all stall, flush and forward outputs are 0 and mcBusy=0.
REQ-034 Reset asserted in MC_BUSY abandons the op with no MC_DONE cycle.
REQ-035 Deassertion is sampled on the next rising clk edge.

Configuration
REQ-036 Macro HAZARD_FWD_EN defined: forwarding per REQ-028, and rawStall=0.
REQ-037 HAZARD_FWD_EN undefined: fwdAe=fwdBe=00 always.
REQ-038 HAZARD_FWD_EN undefined: rawStall = any nonzero ad1d/ad2d equal to rde with regWrte=1, or to rdm with regWrtm=1.
REQ-039 The W stage never causes rawStall; the register file writes on the falling edge.

Verification
REQ-040 ldE=1, rde=5, ad1d=5 in RUN -> stallf=stalld=flushe=1 for one cycle, and stallCnt=1 afterward.
REQ-041 regWrtm=1, rdm=7, ad1e=7 and regWrtw=1, rdw=7, ad2e=7 -> fwdAe=10, fwdBe=01 (HAZARD_FWD_EN defined); with rdm=0 -> fwdAe=00.
REQ-042 MC_LAT=4, mcStarte pulse -> mcBusy=1 and stalls high for 3 cycles, one MC_DONE cycle with stalls low, then RUN.
REQ-043 pcSrce=1 with ldE=1, rde=3, ad2d=3 -> flushd=flushe=1, stallf=1; pcSrce=1 while in MC_BUSY -> flushd=0.
REQ-044 clr_n pulled low in the second MC_BUSY cycle -> immediate RUN, stalls 0, stallCnt=0; stallf held high for 70000 cycles -> stallCnt=0xFFFF.
